mem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the 256 x 8 main data memory. Arbitrates between requester 0 (CPU load/store unit) and requester 1 (I/O / DMA engine) with round-robin fairness. Drives the memory's address, write-data, read and write strobes from registers, and returns read data with a one-cycle acknowledge pulse. It is the only block allowed to drive the memory's control inputs.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter_rr_pick.sv | 17 +
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter slice
//   arbStateT   - 2-bit FSM state type with IDLE / ACCESS / ACK encodings
//   REQ_CPU/IO  - requester ids (0 = load/store unit, 1 = I/O / DMA engine)
//   *_W_DEF     - default address / data widths of the main data memory
package mem_arb_pkg;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   typedef logic [1:0] arbStateT;
   localparam arbStateT IDLE   = 2'd0;
   localparam arbStateT ACCESS = 2'd1;
   localparam arbStateT ACK    = 2'd2;
   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_IO  = 1'b1;
   function automatic logic otherReq(input logic id);
      return ~id;
   endfunction
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational 2-way round-robin picker
//   req[1:0] in  - pending requests
//   pointer  in  - preferred requester when both are pending
//   valid    out - at least one request pending
//   winner   out - id of the chosen requester (meaningful when valid)
module rr_pick
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       pointer,
   output logic       valid,
   output logic       winner
);
   assign valid  = |req;
   // A lone requester wins outright; the pointer only breaks ties.
   assign winner = &req ? pointer : (req[1] ? REQ_IO : REQ_CPU);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and access sequencer for the 256 x 8 data memory
//   clk, reset                 - clock, asynchronous active-high reset
//   req/we/addr/wdata 0 and 1  - requester ports, held stable until ack
//   ack0, ack1                 - one-cycle completion pulses
//   rdata                      - last read result, held until the next read completes
//   mem_addr/mem_wdata         - registered memory address / write data
//   mem_read/mem_write         - registered strobes, high for the whole ACCESS cycle
//   mem_rdata                  - combinational read data from the memory
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);
   arbStateT state;
   logic     pointer;
   logic     grantId;
   logic     pickValid;
   logic     pickWinner;

   rr_pick picker (
      .req    ({req1, req0}),
      .pointer(pointer),
      .valid  (pickValid),
      .winner (pickWinner)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata     <= '0;
         pointer   <= REQ_CPU;
         grantId   <= REQ_CPU;
      end else begin
         case (state)
            IDLE: if (pickValid) begin
               mem_addr  <= pickWinner ? addr1 : addr0;
               mem_wdata <= pickWinner ? wdata1 : wdata0;
               mem_write <= pickWinner ? we1 : we0;
               mem_read  <= ~(pickWinner ? we1 : we0);
               grantId   <= pickWinner;
               state     <= ACCESS;
            end
            // Strobes were high for this whole cycle, so the memory's negedge
            // write has landed and its read data is settled at this edge.
            ACCESS: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               if (mem_read) rdata <= mem_rdata;
               ack0      <= grantId == REQ_CPU;
               ack1      <= grantId == REQ_IO;
               state     <= ACK;
            end
            // Requests are ignored here so a requester can retarget its inputs
            // during the ack cycle without being sampled twice.
            ACK: begin
               ack0    <= 1'b0;
               ack1    <= 1'b0;
               pointer <= otherReq(grantId);
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   strobeExclusive: assert property (@(posedge clk) disable iff (reset) !(mem_read && mem_write));
   ackExclusive: assert property (@(posedge clk) disable iff (reset) !(ack0 && ack1));
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench with a transaction-level reference model
module tb_mem_arbiter;
   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
      int         delay;
   } txnT;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] reqV = '0;
   logic [1:0] weV = '0;
   logic [7:0] addrV [2];
   logic [7:0] dataV [2];
   logic       ack0, ack1, mem_read, mem_write;
   logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(reqV[0]), .req1(reqV[1]), .we0(weV[0]), .we1(weV[1]),
      .addr0(addrV[0]), .addr1(addrV[1]), .wdata0(dataV[0]), .wdata1(dataV[1]),
      .ack0(ack0), .ack1(ack1), .rdata(rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
      .mem_rdata(mem_rdata)
   );

   logic [7:0] mem [256];
   logic       memInit = 1'b0;
   always @(negedge clk) begin
      if (!memInit) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
         memInit <= 1'b1;
      end else if (mem_write) mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr];

   int checkCnt = 0;
   int errCnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: an access is granted at a sampling edge, completes one
   // edge later, and the arbiter can sample again three edges after the grant.
   logic [7:0] modelMem [256];
   int         edgeN = 0;
   int         nextSample = 0;
   int         pendEdge = 0;
   bit         pendValid = 0;
   bit         pendW, pendWe;
   logic [7:0] pendAddr, pendData;
   bit         ptr = 0;
   logic [1:0] expAck;
   bit         expRd, expWr;
   logic [7:0] expRdata = '0, expAddr = '0, expWdata = '0;
   bit         memChk;
   logic [7:0] memChkAddr, memChkData;

   txnT        txQ0 [$];
   txnT        txQ1 [$];
   txnT        cur [2];
   bit         have [2];
   int         ackE0 [$];
   int         ackE1 [$];

   task automatic modelEdge();
      expAck = '0;
      expRd = 0;
      expWr = 0;
      memChk = 0;
      if (reset) begin
         pendValid = 0;
         ptr = 0;
         expRdata = '0;
         expAddr = '0;
         expWdata = '0;
         nextSample = edgeN;
         return;
      end
      if (pendValid && edgeN == pendEdge + 1) begin
         expAck[pendW] = 1'b1;
         if (pendWe) begin
            modelMem[pendAddr] = pendData;
            memChk = 1;
            memChkAddr = pendAddr;
            memChkData = pendData;
         end else expRdata = modelMem[pendAddr];
         pendValid = 0;
      end
      if (edgeN >= nextSample && reqV != 2'b00) begin
         pendW = (reqV == 2'b11) ? ptr : reqV[1];
         pendWe = weV[pendW];
         pendAddr = addrV[pendW];
         pendData = dataV[pendW];
         pendEdge = edgeN;
         pendValid = 1;
         nextSample = edgeN + 3;
         ptr = !pendW;
         expRd = !pendWe;
         expWr = pendWe;
         expAddr = pendAddr;
         expWdata = pendData;
      end
   endtask

   task automatic compareOut();
      check("ack0", 32'(ack0), 32'(expAck[0]));
      check("ack1", 32'(ack1), 32'(expAck[1]));
      check("mem_read", 32'(mem_read), 32'(expRd));
      check("mem_write", 32'(mem_write), 32'(expWr));
      check("rdata", 32'(rdata), 32'(expRdata));
      check("mem_addr", 32'(mem_addr), 32'(expAddr));
      check("mem_wdata", 32'(mem_wdata), 32'(expWdata));
      if (memChk) check("mem_content", 32'(mem[memChkAddr]), 32'(memChkData));
   endtask

   task automatic driveAgents();
      for (int p = 0; p < 2; p++) begin
         if (reqV[p] && (p == 0 ? ack0 : ack1)) reqV[p] = 1'b0;
         if (!reqV[p]) begin
            if (!have[p]) begin
               if (p == 0 && txQ0.size() > 0) begin
                  cur[p] = txQ0.pop_front();
                  have[p] = 1;
               end else if (p == 1 && txQ1.size() > 0) begin
                  cur[p] = txQ1.pop_front();
                  have[p] = 1;
               end
            end
            if (have[p]) begin
               if (cur[p].delay == 0) begin
                  weV[p] = cur[p].we;
                  addrV[p] = cur[p].addr;
                  dataV[p] = cur[p].data;
                  reqV[p] = 1'b1;
                  have[p] = 0;
               end else cur[p].delay--;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edgeN++;
      modelEdge();
      compareOut();
      if (ack0) ackE0.push_back(edgeN);
      if (ack1) ackE1.push_back(edgeN);
      driveAgents();
   endtask

   task automatic pushTxn(input int p, input logic we, input logic [7:0] a, input logic [7:0] d, input int dly);
      txnT t;
      t.we = we;
      t.addr = a;
      t.data = d;
      t.delay = dly;
      if (p == 0) txQ0.push_back(t);
      else txQ1.push_back(t);
   endtask

   task automatic drain();
      int n = 0;
      while ((txQ0.size() != 0 || txQ1.size() != 0 || reqV != 2'b00 || have[0] || have[1] || pendValid) && n < 5000) begin
         step();
         n++;
      end
      check("drain_timeout", 32'(n < 5000), 32'd1);
      repeat (3) step();
   endtask

   initial begin
      int n;
      addrV[0] = '0;
      addrV[1] = '0;
      dataV[0] = '0;
      dataV[1] = '0;
      have[0] = 0;
      have[1] = 0;
      for (int i = 0; i < 256; i++) modelMem[i] = 8'(i) ^ 8'h5A;
      step();
      step();
      @(negedge clk) reset = 1'b0;

      // Contention straight after reset, each side re-requesting in its ack cycle.
      ackE0.delete();
      ackE1.delete();
      pushTxn(0, 0, 8'h40, 8'h00, 0);
      pushTxn(1, 0, 8'h41, 8'h00, 0);
      pushTxn(0, 0, 8'h42, 8'h00, 0);
      pushTxn(1, 0, 8'h43, 8'h00, 0);
      drain();
      check("cont_n0", 32'(ackE0.size()), 32'd2);
      check("cont_n1", 32'(ackE1.size()), 32'd2);
      if (ackE0.size() == 2 && ackE1.size() == 2) begin
         check("cont_gap01", 32'(ackE1[0] - ackE0[0]), 32'd3);
         check("cont_gap10", 32'(ackE0[1] - ackE1[0]), 32'd3);
         check("cont_gap01b", 32'(ackE1[1] - ackE0[1]), 32'd3);
      end

      // Single write then read back.
      pushTxn(0, 1, 8'h10, 8'hA5, 0);
      pushTxn(0, 0, 8'h10, 8'h00, 0);
      drain();
      check("wr_rd_rdata", 32'(rdata), 32'hA5);
      check("wr_rd_mem", 32'(mem[8'h10]), 32'hA5);

      // Sustained load from both sides.
      ackE0.delete();
      ackE1.delete();
      pushTxn(0, 1, 8'h30, 8'h11, 0);
      pushTxn(0, 1, 8'h30, 8'h11, 0);
      pushTxn(1, 1, 8'h31, 8'h22, 0);
      pushTxn(1, 1, 8'h31, 8'h22, 0);
      drain();
      check("sust_acks", 32'(ackE0.size() + ackE1.size()), 32'd4);
      check("sust_mem0", 32'(mem[8'h30]), 32'h11);
      check("sust_mem1", 32'(mem[8'h31]), 32'h22);

      // Read data held across a later write.
      pushTxn(1, 1, 8'hFF, 8'h3C, 0);
      pushTxn(1, 0, 8'hFF, 8'h00, 0);
      drain();
      pushTxn(0, 1, 8'h00, 8'h77, 0);
      drain();
      check("hold_rdata", 32'(rdata), 32'h3C);
      check("hold_mem0", 32'(mem[8'h00]), 32'h77);

      // Single requester back-to-back reads.
      ackE0.delete();
      ackE1.delete();
      for (int i = 0; i < 5; i++) pushTxn(1, 0, 8'(8'h50 + i), 8'h00, 0);
      drain();
      check("single_n1", 32'(ackE1.size()), 32'd5);
      check("single_n0", 32'(ackE0.size()), 32'd0);
      if (ackE1.size() == 5) check("single_span", 32'(ackE1[4] - ackE1[0]), 32'd12);

      // Reset during a write's ACCESS cycle, before the negedge.
      pushTxn(0, 0, 8'h05, 8'h00, 0);
      drain();
      pushTxn(0, 1, 8'h20, 8'h99, 0);
      n = 0;
      while (!mem_write && n < 10) begin
         step();
         n++;
      end
      check("rst_grant_wait", 32'(n < 10), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_read", 32'(mem_read), 32'd0);
      check("rst_write", 32'(mem_write), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_ack0", 32'(ack0), 32'd0);
      reqV = '0;
      have[0] = 0;
      have[1] = 0;
      step();
      step();
      @(negedge clk) reset = 1'b0;
      repeat (4) step();
      check("rst_mem20", 32'(mem[8'h20]), 32'h7A);
      ackE0.delete();
      ackE1.delete();
      pushTxn(0, 0, 8'h01, 8'h00, 0);
      pushTxn(1, 0, 8'h02, 8'h00, 0);
      drain();
      check("rst_ptr", 32'(ackE0.size() == 1 && ackE1.size() == 1 && ackE0[0] < ackE1[0]), 32'd1);

      // Randomized traffic, including boundary addresses.
      for (int i = 0; i < 150; i++) begin
         for (int p = 0; p < 2; p++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF) : 8'($urandom);
            pushTxn(p, 1'($urandom_range(0, 1)), a, 8'($urandom),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
         end
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
      $finish;
   end
endmodule
